// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the ALU operation interface, with a memory-wait watchdog.
module mips_multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter logic [3:0]  OP_ADD     = 4'b0010,
    parameter logic [3:0]  OP_SUB     = 4'b0110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [3:0] ALUOP,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCEn,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic       Fault
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        RTYPE_WB,
        BEQ_EX,
        JUMP,
        FAULT
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;

    // Counter holds up to WAIT_LIMIT+1 so the limit comparison never wraps.
    localparam int unsigned CW    = $clog2(WAIT_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wdog;
    logic [CW-1:0] wdog_inc;
    logic          waiting;
    logic          expired;
    logic          funct_ok;

    assign waiting  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign wdog_inc = wdog + CW'(1);
    assign expired  = (WAIT_LIMIT != 0) && waiting && !MemReady && (wdog_inc == LIMIT);
    assign funct_ok = (Funct == FN_ADD) || (Funct == FN_SUB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            wdog  <= '0;
        end else begin
            state <= next_state;
            if (waiting && !MemReady && (next_state == state))
                wdog <= wdog_inc;
            else
                wdog <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (MemReady) next_state = DECODE;
            DECODE: begin
                if ((Opcode == OPC_LW) || (Opcode == OPC_SW))
                    next_state = MEMADR;
                else if ((Opcode == OPC_RTYPE) && funct_ok)
                    next_state = RTYPE_EX;
                else if (Opcode == OPC_BEQ)
                    next_state = BEQ_EX;
                else if (Opcode == OPC_J)
                    next_state = JUMP;
                else
                    next_state = FETCH;
            end
            MEMADR:   next_state = (Opcode == OPC_LW) ? MEMRD : MEMWR;
            MEMRD:    if (MemReady) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWR:    if (MemReady) next_state = FETCH;
            RTYPE_EX: next_state = RTYPE_WB;
            RTYPE_WB: next_state = FETCH;
            BEQ_EX:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            FAULT:    next_state = FAULT;
            default:  next_state = FETCH;
        endcase
        // A stalled memory beats every other transition.
        if (expired)
            next_state = FAULT;
    end

    // Everything is held low while reset is asserted, including the Fault flag.
    always_comb begin
        ALUOP     = 4'b0000;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        PCEn      = 1'b0;
        PCSource  = 2'b00;
        IllegalOp = 1'b0;
        Fault     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOP   = OP_ADD;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOP   = OP_ADD;
                    IllegalOp = !((Opcode == OPC_LW) || (Opcode == OPC_SW) ||
                                  ((Opcode == OPC_RTYPE) && funct_ok) ||
                                  (Opcode == OPC_BEQ) || (Opcode == OPC_J));
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOP   = OP_ADD;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    if (Funct == FN_ADD)
                        ALUOP = OP_ADD;
                    else if (Funct == FN_SUB)
                        ALUOP = OP_SUB;
                end
                RTYPE_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BEQ_EX: begin
                    ALUSrcA  = 1'b1;
                    ALUOP    = OP_SUB;
                    PCSource = 2'b01;
                    PCEn     = Zero;
                end
                JUMP: begin
                    PCSource = 2'b10;
                    PCEn     = 1'b1;
                end
                FAULT:   Fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multi-cycle MIPS control FSM: expected output vectors
// are queued as each cycle's stimulus is driven and compared mid-cycle.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic [3:0] ALUOP;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       PCEn;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic       Fault;

    typedef struct {
        string       tag;
        logic [18:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  assertCount = 0;
    int  failCount   = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .ALUOP(ALUOP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .Fault(Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] vec(
        input logic [3:0] op, input logic sa, input logic [1:0] sb,
        input logic iord, input logic mrd, input logic mwr, input logic irw,
        input logic rdst, input logic m2r, input logic rw, input logic pcen,
        input logic [1:0] pcs, input logic ill, input logic flt);
        return {op, sa, sb, iord, mrd, mwr, irw, rdst, m2r, rw, pcen, pcs, ill, flt};
    endfunction

    localparam logic [18:0] ZEROV = '0;

    function automatic logic [18:0] fetchV(input logic mr);
        return vec(4'b0010, 0, 2'b01, 0, 1, 0, mr, 0, 0, 0, mr, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] decodeV(input logic ill);
        return vec(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ill, 0);
    endfunction
    function automatic logic [18:0] memadrV();
        return vec(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] memrdV();
        return vec(4'b0000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] memwbV();
        return vec(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] memwrV();
        return vec(4'b0000, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] rtexV(input logic [3:0] op);
        return vec(op, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] rtwbV();
        return vec(4'b0000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] beqV(input logic z);
        return vec(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, z, 2'b01, 0, 0);
    endfunction
    function automatic logic [18:0] jumpV();
        return vec(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    endfunction
    function automatic logic [18:0] faultV();
        return vec(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, then compare mid-cycle.
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic mr, input string tag,
                                 input logic [18:0] exp);
        sb_t e;
        reset    = rst;
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        MemReady = mr;
        sbq.push_back('{tag, exp});
        @(negedge clk);
        e = sbq.pop_front();
        checkOutput(e.tag,
                    {ALUOP, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegDst,
                     MemtoReg, RegWrite, PCEn, PCSource, IllegalOp, Fault}, e.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic runRtype(input logic [5:0] fn, input logic [3:0] op, input string tag);
        applyStimulus(0, 6'b000000, fn, 0, 1, {tag, "_fetch"}, fetchV(1));
        applyStimulus(0, 6'b000000, fn, 0, 1, {tag, "_decode"}, decodeV(0));
        applyStimulus(0, 6'b000000, fn, 0, 1, {tag, "_ex"}, rtexV(op));
        applyStimulus(0, 6'b000000, fn, 0, 1, {tag, "_wb"}, rtwbV());
    endtask

    task automatic runBeq(input logic z, input string tag);
        applyStimulus(0, 6'b000100, 6'd0, z, 1, {tag, "_fetch"}, fetchV(1));
        applyStimulus(0, 6'b000100, 6'd0, z, 1, {tag, "_decode"}, decodeV(0));
        applyStimulus(0, 6'b000100, 6'd0, z, 1, {tag, "_ex"}, beqV(z));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
        applyStimulus(1, 6'd0, 6'd0, 0, 1, "reset0", ZEROV);
        applyStimulus(1, 6'd0, 6'd0, 0, 1, "reset1", ZEROV);

        runRtype(6'b100000, 4'b0010, "add");
        runRtype(6'b100010, 4'b0110, "sub");

        applyStimulus(0, 6'b100011, 6'd0, 0, 1, "lw_fetch", fetchV(1));
        applyStimulus(0, 6'b100011, 6'd0, 0, 1, "lw_decode", decodeV(0));
        applyStimulus(0, 6'b100011, 6'd0, 0, 1, "lw_memadr", memadrV());
        applyStimulus(0, 6'b100011, 6'd0, 0, 0, "lw_memrd_w0", memrdV());
        applyStimulus(0, 6'b100011, 6'd0, 0, 0, "lw_memrd_w1", memrdV());
        applyStimulus(0, 6'b100011, 6'd0, 0, 1, "lw_memrd", memrdV());
        applyStimulus(0, 6'b100011, 6'd0, 0, 1, "lw_memwb", memwbV());

        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "sw_fetch", fetchV(1));
        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "sw_decode", decodeV(0));
        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "sw_memadr", memadrV());
        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "sw_memwr", memwrV());

        runBeq(1'b1, "beq_taken");
        runBeq(1'b0, "beq_not_taken");

        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "j_fetch", fetchV(1));
        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "j_decode", decodeV(0));
        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "j_jump", jumpV());

        applyStimulus(0, 6'b001111, 6'd0, 0, 1, "ill_op_fetch", fetchV(1));
        applyStimulus(0, 6'b001111, 6'd0, 0, 1, "ill_op_decode", decodeV(1));
        applyStimulus(0, 6'b000000, 6'b100100, 0, 1, "ill_fn_fetch", fetchV(1));
        applyStimulus(0, 6'b000000, 6'b100100, 0, 1, "ill_fn_decode", decodeV(1));

        for (int i = 0; i < 15; i++)
            applyStimulus(0, 6'd0, 6'd0, 0, 0, $sformatf("stall_fetch%0d", i), fetchV(0));
        applyStimulus(0, 6'd0, 6'd0, 0, 0, "fault0", faultV());
        applyStimulus(0, 6'd0, 6'd0, 1, 1, "fault1", faultV());
        applyStimulus(0, 6'd0, 6'd0, 0, 1, "fault2", faultV());
        applyStimulus(1, 6'd0, 6'd0, 0, 1, "fault_reset", ZEROV);

        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "abort_fetch", fetchV(1));
        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "abort_decode", decodeV(0));
        applyStimulus(0, 6'b101011, 6'd0, 0, 1, "abort_memadr", memadrV());
        applyStimulus(0, 6'b101011, 6'd0, 0, 0, "abort_memwr", memwrV());
        applyStimulus(1, 6'b101011, 6'd0, 0, 0, "abort_reset", ZEROV);

        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "post_fetch", fetchV(1));
        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "post_decode", decodeV(0));
        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "post_jump", jumpV());
        applyStimulus(0, 6'b000010, 6'd0, 0, 1, "post_fetch2", fetchV(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
